// File: rtl/cc_lives_counter_pkg.sv
// ---------------------------------------------------------------------------
// cc_lives_counter_pkg
//   Shared definitions for the frog lives path. The lives comparator imports
//   the same MAX_DEATHS default so that the two blocks cannot disagree about
//   when the game is over.
//
//   Contents:
//     lives_state_t               state encoding: ALIVE=0, INVULN=1, OVER=2
//     LIVES_DEFAULT_MAX_DEATHS    death count that ends the game
//     LIVES_DEFAULT_INVULN_CYCLES invulnerability length (1 s at 50 MHz)
//
//   Optional feature macro used by the counter: LIVES_COUNTER_BONUS_EN
// ---------------------------------------------------------------------------
package cc_lives_counter_pkg;

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVULN = 2'd1,
        ST_OVER   = 2'd2
    } lives_state_t;

    localparam int LIVES_DEFAULT_MAX_DEATHS    = 5;
    localparam int LIVES_DEFAULT_INVULN_CYCLES = 50_000_000;

endpackage

// File: rtl/cc_rising_edge_detector.sv
// ---------------------------------------------------------------------------
// cc_rising_edge_detector
//   Turns a same-domain level into a single-cycle event on its rising edge.
//   The history flop presets to 1, so a level that is already high when
//   reset is released is not reported as an event.
//
//   Ports:
//     i_clk    in  1  clock
//     i_rst    in  1  asynchronous reset, active-high
//     i_level  in  1  level to watch (already synchronous to i_clk)
//     o_event  out 1  level & ~previous level (combinational from the flop)
// ---------------------------------------------------------------------------
module cc_rising_edge_detector (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_level,
    output logic o_event
);

    logic r_level_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_level_q <= 1'b1;
        end else begin
            r_level_q <= i_level;
        end
    end

    assign o_event = i_level & ~r_level_q;

endmodule

// File: rtl/cc_lives_counter.sv
// ---------------------------------------------------------------------------
// cc_lives_counter
//   Counts frog deaths. Each rising edge of the collision level is one hit.
//   A non-fatal hit starts an invulnerability window of INVULN_CYCLES cycles
//   during which further hits are ignored; the hit that brings the count to
//   MAX_DEATHS ends the game and the count then holds until restart/reset.
//
//   Optional feature: define LIVES_COUNTER_BONUS_EN to add the bonus port.
//   A bonus rising edge removes one death (never below 0, never in OVER).
//
//   Ports:
//     CC_LIVES_COUNTER_CLOCK_50          in   1   game-logic clock
//     CC_LIVES_COUNTER_RESET_InHigh      in   1   async reset, active-high
//     CC_LIVES_COUNTER_hit_InHigh        in   1   collision level
//     CC_LIVES_COUNTER_restart_InHigh    in   1   synchronous new-game clear
//     CC_LIVES_COUNTER_bonus_InHigh      in   1   extra-life level (bonus build)
//     CC_LIVES_COUNTER_data_Out          out  DW  death count -> comparator
//     CC_LIVES_COUNTER_respawn_OutHigh   out  1   pulse on accepted non-fatal hit
//     CC_LIVES_COUNTER_invuln_OutHigh    out  1   high during invulnerability
//     CC_LIVES_COUNTER_gameover_OutHigh  out  1   high while in OVER
//     o_dbg_state                        out  2   current FSM state encoding
// ---------------------------------------------------------------------------
module cc_lives_counter
    import cc_lives_counter_pkg::*;
#(
    parameter int LIVES_COUNTER_DATAWIDTH = 3,
    parameter int MAX_DEATHS              = LIVES_DEFAULT_MAX_DEATHS,
    parameter int INVULN_CYCLES           = LIVES_DEFAULT_INVULN_CYCLES,
    parameter int INVULN_WIDTH            = 26
) (
    input  logic                               CC_LIVES_COUNTER_CLOCK_50,
    input  logic                               CC_LIVES_COUNTER_RESET_InHigh,
    input  logic                               CC_LIVES_COUNTER_hit_InHigh,
    input  logic                               CC_LIVES_COUNTER_restart_InHigh,
`ifdef LIVES_COUNTER_BONUS_EN
    input  logic                               CC_LIVES_COUNTER_bonus_InHigh,
`endif
    output logic [LIVES_COUNTER_DATAWIDTH-1:0] CC_LIVES_COUNTER_data_Out,
    output logic                               CC_LIVES_COUNTER_respawn_OutHigh,
    output logic                               CC_LIVES_COUNTER_invuln_OutHigh,
    output logic                               CC_LIVES_COUNTER_gameover_OutHigh,
    output logic [1:0]                         o_dbg_state
);

    localparam logic [LIVES_COUNTER_DATAWIDTH-1:0] L_MAX_COUNT =
        LIVES_COUNTER_DATAWIDTH'(MAX_DEATHS);
    // Loading N-1 and leaving at 0 keeps invuln high for exactly N cycles.
    localparam logic [INVULN_WIDTH-1:0] L_TIMER_LOAD =
        INVULN_WIDTH'(INVULN_CYCLES - 1);

    lives_state_t                       r_state;
    logic [LIVES_COUNTER_DATAWIDTH-1:0] r_count;
    logic [INVULN_WIDTH-1:0]            r_timer;
    logic                               r_respawn;
    logic                               r_invuln;
    logic                               r_gameover;

    lives_state_t                       w_state_nxt;
    logic [LIVES_COUNTER_DATAWIDTH-1:0] w_count_nxt;
    logic [LIVES_COUNTER_DATAWIDTH-1:0] w_count_inc;
    logic [INVULN_WIDTH-1:0]            w_timer_nxt;
    logic                               w_respawn_nxt;
    logic                               w_hit_ev;
    logic                               w_bonus_ev;
    logic                               w_bonus_take;

    cc_rising_edge_detector u_hit_edge (
        .i_clk   (CC_LIVES_COUNTER_CLOCK_50),
        .i_rst   (CC_LIVES_COUNTER_RESET_InHigh),
        .i_level (CC_LIVES_COUNTER_hit_InHigh),
        .o_event (w_hit_ev)
    );

`ifdef LIVES_COUNTER_BONUS_EN
    cc_rising_edge_detector u_bonus_edge (
        .i_clk   (CC_LIVES_COUNTER_CLOCK_50),
        .i_rst   (CC_LIVES_COUNTER_RESET_InHigh),
        .i_level (CC_LIVES_COUNTER_bonus_InHigh),
        .o_event (w_bonus_ev)
    );
`else
    assign w_bonus_ev = 1'b0;
`endif

    // A bonus only counts when there is a death to give back.
    assign w_bonus_take = w_bonus_ev & (r_count != '0);
    assign w_count_inc  = r_count + 1'b1;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_timer_nxt   = r_timer;
        w_respawn_nxt = 1'b0;

        if (CC_LIVES_COUNTER_restart_InHigh) begin
            // Restart wins over any hit or bonus in the same cycle.
            w_state_nxt = ST_ALIVE;
            w_count_nxt = '0;
            w_timer_nxt = '0;
        end else begin
            case (r_state)
                ST_ALIVE: begin
                    if (w_hit_ev) begin
                        if (w_bonus_take) begin
                            // Hit and bonus cancel on the count, but the
                            // frog still respawns with invulnerability.
                            w_state_nxt   = ST_INVULN;
                            w_timer_nxt   = L_TIMER_LOAD;
                            w_respawn_nxt = 1'b1;
                        end else if (w_count_inc == L_MAX_COUNT) begin
                            w_state_nxt = ST_OVER;
                            w_count_nxt = w_count_inc;
                        end else begin
                            w_state_nxt   = ST_INVULN;
                            w_count_nxt   = w_count_inc;
                            w_timer_nxt   = L_TIMER_LOAD;
                            w_respawn_nxt = 1'b1;
                        end
                    end else if (w_bonus_take) begin
                        w_count_nxt = r_count - 1'b1;
                    end
                end

                ST_INVULN: begin
                    if (w_bonus_take) begin
                        w_count_nxt = r_count - 1'b1;
                    end
                    if (r_timer == '0) begin
                        w_state_nxt = ST_ALIVE;
                    end else begin
                        w_timer_nxt = r_timer - 1'b1;
                    end
                end

                ST_OVER: begin
                    // Everything held until restart or reset.
                end

                default: begin
                    // Unused encoding: recover to a fresh game.
                    w_state_nxt = ST_ALIVE;
                    w_count_nxt = '0;
                    w_timer_nxt = '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CC_LIVES_COUNTER_CLOCK_50 or posedge CC_LIVES_COUNTER_RESET_InHigh) begin
        if (CC_LIVES_COUNTER_RESET_InHigh) begin
            r_state    <= ST_ALIVE;
            r_count    <= '0;
            r_timer    <= '0;
            r_respawn  <= 1'b0;
            r_invuln   <= 1'b0;
            r_gameover <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_timer    <= w_timer_nxt;
            r_respawn  <= w_respawn_nxt;
            r_invuln   <= (w_state_nxt == ST_INVULN);
            r_gameover <= (w_state_nxt == ST_OVER);
        end
    end

    assign CC_LIVES_COUNTER_data_Out         = r_count;
    assign CC_LIVES_COUNTER_respawn_OutHigh  = r_respawn;
    assign CC_LIVES_COUNTER_invuln_OutHigh   = r_invuln;
    assign CC_LIVES_COUNTER_gameover_OutHigh = r_gameover;
    assign o_dbg_state                       = r_state;

endmodule

// File: tb/tb_cc_lives_counter.sv
// ---------------------------------------------------------------------------
// tb_cc_lives_counter
//   Directed and randomized stimulus for cc_lives_counter with a small
//   game-rules model (deaths, remaining invulnerable cycles, game-over flag).
//   Build with +define+LIVES_COUNTER_BONUS_EN to also exercise the bonus port.
// ---------------------------------------------------------------------------
module tb_cc_lives_counter;

    localparam int DW   = 3;
    localparam int MAXD = 5;
    localparam int INV  = 4;
    localparam int IW   = 3;

`ifdef LIVES_COUNTER_BONUS_EN
    localparam bit BONUS_EN = 1'b1;
`else
    localparam bit BONUS_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic hit     = 1'b1;
    logic restart = 1'b0;
    logic bonus   = 1'b0;

    logic [DW-1:0] data_out;
    logic          respawn;
    logic          invuln;
    logic          gameover;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    cc_lives_counter #(
        .LIVES_COUNTER_DATAWIDTH (DW),
        .MAX_DEATHS              (MAXD),
        .INVULN_CYCLES           (INV),
        .INVULN_WIDTH            (IW)
    ) dut (
        .CC_LIVES_COUNTER_CLOCK_50         (clk),
        .CC_LIVES_COUNTER_RESET_InHigh     (rst),
        .CC_LIVES_COUNTER_hit_InHigh       (hit),
        .CC_LIVES_COUNTER_restart_InHigh   (restart),
`ifdef LIVES_COUNTER_BONUS_EN
        .CC_LIVES_COUNTER_bonus_InHigh     (bonus),
`endif
        .CC_LIVES_COUNTER_data_Out         (data_out),
        .CC_LIVES_COUNTER_respawn_OutHigh  (respawn),
        .CC_LIVES_COUNTER_invuln_OutHigh   (invuln),
        .CC_LIVES_COUNTER_gameover_OutHigh (gameover),
        .o_dbg_state                       (dbg_state)
    );

    // ---------------- reference model ----------------
    int   checks   = 0;
    int   failures = 0;
    int   m_deaths;
    int   m_invuln_left;   // invulnerable cycles still to show, including this one
    bit   m_over;
    bit   m_respawn;
    logic m_prev_hit;
    logic m_prev_bonus;

    function automatic void model_reset();
        m_deaths      = 0;
        m_invuln_left = 0;
        m_over        = 1'b0;
        m_respawn     = 1'b0;
        m_prev_hit    = 1'b1;
        m_prev_bonus  = 1'b1;
    endfunction

    function automatic void model_step(input logic h, input logic r, input logic b);
        bit hit_ev;
        bit bon_ok;
        hit_ev       = h && !m_prev_hit;
        bon_ok       = BONUS_EN && b && !m_prev_bonus && (m_deaths > 0);
        m_prev_hit   = h;
        m_prev_bonus = b;
        m_respawn    = 1'b0;
        if (r) begin
            m_deaths      = 0;
            m_invuln_left = 0;
            m_over        = 1'b0;
        end else if (!m_over) begin
            if (m_invuln_left > 0) begin
                m_invuln_left--;
                if (bon_ok) m_deaths--;
            end else if (hit_ev) begin
                if (!bon_ok) m_deaths++;
                if (!bon_ok && m_deaths == MAXD) begin
                    m_over = 1'b1;
                end else begin
                    m_invuln_left = INV;
                    m_respawn     = 1'b1;
                end
            end else if (bon_ok) begin
                m_deaths--;
            end
        end
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int exp_state;
        exp_state = m_over ? 2 : ((m_invuln_left > 0) ? 1 : 0);
        check({tag, ".count"},    32'(data_out),  32'(m_deaths));
        check({tag, ".respawn"},  32'(respawn),   32'(m_respawn));
        check({tag, ".invuln"},   32'(invuln),    32'(m_invuln_left > 0));
        check({tag, ".gameover"}, 32'(gameover),  32'(m_over));
        check({tag, ".state"},    32'(dbg_state), 32'(exp_state));
    endtask

    // ---------------- driver ----------------
    task automatic tick(input string tag);
        @(posedge clk);
        model_step(hit, restart, bonus);
        #1;
        check_all(tag);
    endtask

    task automatic hit_and_wait(input string tag, input int gap);
        hit = 1'b1;
        tick(tag);
        hit = 1'b0;
        repeat (gap - 1) tick({tag, "_gap"});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();

        // Reset with hit held high: releasing reset must not produce a hit.
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;
        tick("held_hit_1");
        tick("held_hit_2");
        check("held_hit_no_count", 32'(data_out), 32'd0);
        hit = 1'b0;
        tick("hit_fall");
        hit = 1'b1;
        tick("hit_rise");
        check("first_hit_count", 32'(data_out), 32'd1);
        check("first_hit_respawn", 32'(respawn), 32'd1);

        // Invulnerability window: hits inside it are ignored.
        hit = 1'b0;
        tick("inv_1");
        check("respawn_one_cycle", 32'(respawn), 32'd0);
        hit = 1'b1;
        tick("inv_2_hit_ignored");
        hit = 1'b0;
        tick("inv_3");
        check("invuln_last_cycle", 32'(invuln), 32'd1);
        tick("inv_end");
        check("invuln_window_end", 32'(invuln), 32'd0);
        check("invuln_hits_ignored", 32'(data_out), 32'd1);

        // Five hits six cycles apart, then a sixth on game over.
        restart = 1'b1;
        tick("restart_a");
        restart = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            hit = 1'b1;
            tick("death_seq");
            check("death_seq_count", 32'(data_out), 32'((i < MAXD) ? i : MAXD));
            check("death_seq_over", 32'(gameover), 32'(i >= MAXD));
            check("death_seq_respawn", 32'(respawn), 32'(i < MAXD));
            hit = 1'b0;
            repeat (5) tick("death_seq_gap");
        end

        // Restart together with a hit while invulnerable at count 3.
        restart = 1'b1;
        tick("restart_b");
        restart = 1'b0;
        hit_and_wait("to_three", 6);
        hit_and_wait("to_three", 6);
        hit = 1'b1;
        tick("third_hit");
        hit = 1'b0;
        tick("third_inv");
        check("count_three_inv", 32'(data_out), 32'd3);
        restart = 1'b1;
        hit     = 1'b1;
        tick("restart_beats_hit");
        check("restart_count", 32'(data_out), 32'd0);
        check("restart_invuln", 32'(invuln), 32'd0);
        restart = 1'b0;
        tick("hit_held_over_restart");
        check("held_over_restart", 32'(data_out), 32'd0);
        hit = 1'b0;
        tick("post_restart");

`ifdef LIVES_COUNTER_BONUS_EN
        hit_and_wait("bonus_pre", 6);
        hit_and_wait("bonus_pre", 6);
        bonus = 1'b1;
        tick("bonus_2to1");
        check("bonus_dec", 32'(data_out), 32'd1);
        bonus = 1'b0;
        tick("bonus_gap");
        bonus = 1'b1;
        tick("bonus_1to0");
        bonus = 1'b0;
        tick("bonus_gap");
        bonus = 1'b1;
        tick("bonus_at_zero");
        check("bonus_floor", 32'(data_out), 32'd0);
        bonus = 1'b0;
        tick("bonus_gap");
        for (int i = 0; i < 4; i++) hit_and_wait("to_four", 6);
        hit   = 1'b1;
        bonus = 1'b1;
        tick("hit_bonus_same");
        check("hit_bonus_count", 32'(data_out), 32'd4);
        check("hit_bonus_respawn", 32'(respawn), 32'd1);
        check("hit_bonus_not_over", 32'(gameover), 32'd0);
        hit   = 1'b0;
        bonus = 1'b0;
        repeat (6) tick("hit_bonus_after");
`endif

        // Randomized play.
        for (int i = 0; i < 800; i++) begin
            hit     = ($urandom_range(0, 2) == 0);
            restart = ($urandom_range(0, 59) == 0);
            bonus   = BONUS_EN && ($urandom_range(0, 6) == 0);
            tick("random");
        end
        hit     = 1'b0;
        restart = 1'b1;
        bonus   = 1'b0;
        tick("restart_c");
        restart = 1'b0;

        // Asynchronous reset in the middle of invulnerability (timer at 2).
        hit = 1'b1;
        tick("async_pre_hit");
        hit = 1'b0;
        tick("async_timer2");
        check("async_pre_invuln", 32'(invuln), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        rst = 1'b0;
        tick("after_async_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
